fetch_sequencer: RTL and testbench

- Sequences the uPOWER instruction-fetch datapath: owns the PC, drives the word index into the instruction memory and registers the fetched word toward decode through a valid/ready handshake.
- Applies branch redirects resolved downstream (BEQ/BNE using the ALU zero flag) and squashes wrong-path fetches.
- Detects out-of-range or misaligned PCs and parks in a fault/halt state.

---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: uPOWER instruction-fetch sequencer (PC owner, imem indexing, decode handshake, branch redirect, fault halt)
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   imem_idx / imem_rdata    word index to instruction memory, combinational read data back
//   instr_out/instr_pc       registered instruction and its byte PC toward decode
//   instr_valid/instr_ready  output handshake, transfer on valid & ready
//   br_valid/br_eq/br_ne/zero_flag/br_pc/br_imm  downstream branch resolution
//   pc, fault, halted, fetch_count               status
// Optional: define FETCH_HALT_ON_ZERO_EN to halt (without fault) on a fetched all-zero word.
module fetch_sequencer #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_0004_0000,
  parameter int          IMEM_DEPTH  = 101,
  parameter int          IDX_W       = 7,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] imem_idx,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic [63:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             br_valid,
  input  logic             br_eq,
  input  logic             br_ne,
  input  logic             zero_flag,
  input  logic [63:0]      br_pc,
  input  logic [63:0]      br_imm,
  output logic [63:0]      pc,
  output logic             fault,
  output logic             halted,
  output logic [31:0]      fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, HALT} state_e;
  localparam int BW = $clog2(BOOT_CYCLES + 2);
  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(4 * IMEM_DEPTH);
  state_e        state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [63:0]   pc_q, pc_d, instr_pc_q, instr_pc_d;
  logic [31:0]   instr_out_q, instr_out_d, fetch_count_q, fetch_count_d;
  logic          instr_valid_q, instr_valid_d, fault_q, fault_d, halted_q, halted_d;
  logic          taken, free, bad_pc, boot_done, zero_halt;
  assign imem_idx  = IDX_W'((pc_q - BASE_ADDR) >> 2);
  assign taken     = br_valid & ((br_eq & zero_flag) | (br_ne & ~zero_flag));
  assign free      = ~instr_valid_q | instr_ready;
  assign bad_pc    = (pc_q[1:0] != 2'b00) | (pc_q < BASE_ADDR) | (pc_q >= END_ADDR);
  assign boot_done = 32'(boot_cnt_q) + 32'd1 >= 32'(BOOT_CYCLES);
`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_halt = imem_rdata == 32'h0;
`else
  assign zero_halt = 1'b0;
`endif
  // RUN and HOLD share one path: HOLD is simply RUN while the output register is occupied.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pc_d          = pc_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q + 32'(instr_valid_q & instr_ready);
    if (state_q == BOOT) begin
      boot_cnt_d = boot_cnt_q + BW'(1);
      state_d    = boot_done ? RUN : BOOT;
    end else if (state_q == HALT) begin
      instr_valid_d = 1'b0;
    end else if (taken) begin
      // redirect wins over backpressure and squashes whatever is in the output register
      pc_d          = br_pc + (br_imm << 2);
      instr_valid_d = 1'b0;
      state_d       = RUN;
    end else if (!free) begin
      state_d = HOLD;
    end else if (bad_pc) begin
      instr_valid_d = 1'b0;
      fault_d       = 1'b1;
      halted_d      = 1'b1;
      state_d       = HALT;
    end else if (zero_halt) begin
      instr_valid_d = 1'b0;
      halted_d      = 1'b1;
      state_d       = HALT;
    end else begin
      instr_out_d   = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + 64'd4;
      state_d       = RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      boot_cnt_q    <= '0;
      pc_q          <= BASE_ADDR;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      pc_q          <= pc_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign pc          = pc_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed check of fetch_sequencer against a behavioural model
module tb_fetch_sequencer;
  localparam logic [63:0] BASE  = 64'h0000_0000_0004_0000;
  localparam int          DEPTH = 101;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HOZ = 1'b1;
`else
  localparam bit HOZ = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic [6:0]  imem_idx;
  logic [31:0] imem_rdata, instr_out, fetch_count;
  logic [63:0] instr_pc, pc;
  logic        instr_valid, fault, halted;
  logic        instr_ready = 1'b0, br_valid = 1'b0, br_eq = 1'b0, br_ne = 1'b0, zero_flag = 1'b0;
  logic [63:0] br_pc = '0, br_imm = '0;
  logic [31:0] mem [0:127];
  logic [63:0] m_pc, m_opc;
  logic [31:0] m_out, m_cnt;
  logic        m_valid, m_fault, m_halt;
  int          boot_left;
  int          n_chk = 0, n_pass = 0;
  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_idx(imem_idx), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_valid(br_valid), .br_eq(br_eq), .br_ne(br_ne),
    .zero_flag(zero_flag), .br_pc(br_pc), .br_imm(br_imm), .pc(pc),
    .fault(fault), .halted(halted), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_idx];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic model();
    logic [31:0] w;
    if (m_valid && instr_ready) m_cnt++;
    if (boot_left > 0) boot_left--;
    else if (!m_halt) begin
      if (br_valid && ((br_eq && zero_flag) || (br_ne && !zero_flag))) begin
        m_pc = br_pc + (br_imm << 2);
        m_valid = 1'b0;
      end else if (!m_valid || instr_ready) begin
        if (m_pc[1:0] != 2'b00 || m_pc < BASE || m_pc >= BASE + 64'(4 * DEPTH)) begin
          m_valid = 1'b0; m_fault = 1'b1; m_halt = 1'b1;
        end else begin
          w = mem[int'((m_pc - BASE) / 4)];
          if (HOZ && w == 32'h0) begin
            m_valid = 1'b0; m_halt = 1'b1;
          end else begin
            m_out = w; m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
          end
        end
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("valid", 64'(instr_valid), 64'(m_valid));
    chk("instr_pc", instr_pc, m_opc);
    chk("instr_out", 64'(instr_out), 64'(m_out));
    chk("fault", 64'(fault), 64'(m_fault));
    chk("halted", 64'(halted), 64'(m_halt));
    chk("count", 64'(fetch_count), 64'(m_cnt));
    chk("idx", 64'(imem_idx), 64'(7'((m_pc - BASE) / 4)));
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, BASE);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_out", 64'(instr_out), 64'd0);
    chk("rst_ipc", instr_pc, 64'd0);
    chk("rst_count", 64'(fetch_count), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    br_valid = 1'b0;
    instr_ready = 1'b1;
    m_pc = BASE; m_opc = '0; m_out = '0; m_cnt = '0;
    m_valid = 1'b0; m_fault = 1'b0; m_halt = 1'b0; boot_left = 2;
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom | 32'h1;
    do_reset();
    step(); step();
    chk("boot_quiet", 64'(instr_valid), 64'd0);
    step();
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_pc", instr_pc, 64'h40000);
    step();
    chk("seq1", instr_pc, 64'h40004);
    step();
    chk("seq2", instr_pc, 64'h40008);
    instr_ready = 1'b0;
    repeat (4) step();
    chk("hold_ipc", instr_pc, 64'h40008);
    chk("hold_pc", pc, 64'h4000C);
    instr_ready = 1'b1;
    step();
    chk("resume", instr_pc, 64'h4000C);
    br_valid = 1'b1; br_eq = 1'b1; br_ne = 1'b0; zero_flag = 1'b1;
    br_pc = 64'h40004; br_imm = 64'd5;
    step();
    br_valid = 1'b0;
    chk("redir_pc", pc, 64'h40018);
    chk("squash", 64'(instr_valid), 64'd0);
    step();
    chk("target_pc", instr_pc, 64'h40018);
    chk("target_valid", 64'(instr_valid), 64'd1);
    br_valid = 1'b1; br_eq = 1'b0; br_ne = 1'b1; zero_flag = 1'b1;
    step();
    br_valid = 1'b0;
    chk("not_taken", instr_pc, 64'h4001C);
    br_valid = 1'b1; br_eq = 1'b1; br_ne = 1'b0; zero_flag = 1'b1;
    br_pc = 64'h40004; br_imm = 64'hFFFF_FFFF_FFFE_FFFF;
    step();
    br_valid = 1'b0;
    step();
    chk("bad_fault", 64'(fault), 64'd1);
    chk("bad_halted", 64'(halted), 64'd1);
    repeat (3) step();
    chk("sticky_fault", 64'(fault), 64'd1);
    chk("halt_valid", 64'(instr_valid), 64'd0);
    do_reset();
    repeat (5) step();
    instr_ready = 1'b0;
    repeat (2) step();
    do_reset();
    repeat (6) step();
    mem[4] = 32'h0;
    do_reset();
    repeat (7) step();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("zero_halted", 64'(halted), 64'd1);
    chk("zero_fault", 64'(fault), 64'd0);
    chk("zero_pc", pc, 64'h40010);
`else
    chk("zero_word", 64'(instr_out), 64'd0);
    chk("zero_ipc", instr_pc, 64'h40010);
`endif
    mem[4] = $urandom | 32'h1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      int w, t;
      w = int'($urandom_range(DEPTH - 1));
      t = int'($urandom_range(DEPTH - 1));
      if ($urandom_range(50) == 0) t = DEPTH + int'($urandom_range(5));
      if ($urandom_range(50) == 0) t = -1 - int'($urandom_range(5));
      instr_ready = $urandom_range(3) != 0;
      br_valid    = $urandom_range(7) == 0;
      br_eq       = 1'($urandom_range(1));
      br_ne       = 1'($urandom_range(1));
      zero_flag   = 1'($urandom_range(1));
      br_pc  = BASE + 64'(4 * w) + (($urandom_range(40) == 0) ? 64'd2 : 64'd0);
      br_imm = 64'(longint'(t - w));
      step();
      if (m_halt && $urandom_range(5) == 0) do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
